register_file_mp_arbiter: RTL

Shares one `register_file_1w_multi_port_read` instance (1 write port, N_READ read ports) among N_REQ read requesters and N_WR write requesters. Each cycle it allocates free read ports to requesters round-robin and arbitrates the single write port round-robin. It blocks reads that collide with the same-cycle write, and it routes the one-cycle-latency read data back to the issuing requester. It sits between the cluster-side requesters and the register file.

---
 rtl/register_file_mp_arbiter_pkg.sv | 17 +
 rtl/register_file_mp_arbiter_rf_rr_arb.sv | 54 +++++
 rtl/register_file_mp_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/register_file_mp_arbiter_pkg.sv
// Shared types and helpers for the multi-port register file arbiter.
package register_file_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_READ_DEF     = 2;
    localparam int PORT_IDX_W     = $clog2(N_READ_DEF);

    typedef logic [ADDR_WIDTH_DEF-1:0] rf_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] rf_data_t;

    // Index found idx positions after ptr in a cyclic order of n entries.
    function automatic int rr_next(input int ptr, input int idx, input int n);
        return (ptr + idx) % n;
    endfunction

endpackage

// File: rtl/register_file_mp_arbiter_rf_rr_arb.sv
// 1-of-N round-robin arbiter; the pointer moves one past the last winner.
module rf_rr_arb
    import register_file_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            pos;
    int            best_pos;
    int            best_idx;

    // Pick the active requester closest to the pointer in cyclic order.
    always_comb begin
        gnt_o    = '0;
        ptr_d    = ptr_q;
        pos      = 0;
        best_pos = N;
        best_idx = 0;
        for (int i = 0; i < N; i++) begin
            pos = (i + N - int'(ptr_q)) % N;
            if (req_i[i] && (pos < best_pos)) begin
                best_pos = pos;
                best_idx = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if ((best_pos < N) && (i == best_idx)) begin
                gnt_o[i] = 1'b1;
            end
        end
        if (best_pos < N) begin
            ptr_d = PW'(rr_next(best_idx, 1, N));
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/register_file_mp_arbiter.sv
// Shares one 1-write / N_READ-read register file among N_REQ readers and
// N_WR writers; reads hitting the same-cycle write address are held off.
module register_file_mp_arbiter
    import register_file_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 2,
    parameter int N_REQ      = 4,
    parameter int N_WR       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             rreq_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  raddr_i,
    output logic [N_REQ-1:0]             rgnt_o,
    output logic [N_REQ-1:0]             rvalid_o,
    output logic [N_REQ*DATA_WIDTH-1:0]  rdata_o,
    input  logic [N_WR-1:0]              wreq_i,
    input  logic [N_WR*ADDR_WIDTH-1:0]   waddr_i,
    input  logic [N_WR*DATA_WIDTH-1:0]   wdata_i,
    output logic [N_WR-1:0]              wgnt_o,
    output logic [N_READ-1:0]            ReadEnable,
    output logic [N_READ*ADDR_WIDTH-1:0] ReadAddr,
    input  logic [N_READ*DATA_WIDTH-1:0] ReadData,
    output logic                         WriteEnable,
    output logic [ADDR_WIDTH-1:0]        WriteAddr,
    output logic [DATA_WIDTH-1:0]        WriteData
);

    localparam int PW = (N_READ > 1) ? $clog2(N_READ) : 1;
    localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [RW-1:0]   rd_ptr_q;
    logic [RW-1:0]   rd_ptr_d;
    logic [N_REQ-1:0] granted_q;
    logic [PW-1:0]   port_q [N_REQ];
    logic [PW-1:0]   port_d [N_REQ];
    logic [N_REQ-1:0] elig;
    int              pos  [N_REQ];
    int              rank [N_REQ];
    int              last_pos;
    int              last_idx;
    logic            any_rd;

    rf_rr_arb #(.N(N_WR)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (wreq_i),
        .gnt_o (wgnt_o)
    );

    // Steer the winning writer onto the register file write port.
    always_comb begin
        WriteEnable = |wgnt_o;
        WriteAddr   = '0;
        WriteData   = '0;
        for (int w = 0; w < N_WR; w++) begin
            if (wgnt_o[w]) begin
                WriteAddr = waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
                WriteData = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Rank eligible readers by cyclic distance from the pointer; the first
    // N_READ ranks get grants and rank k drives read port k.
    always_comb begin
        rgnt_o     = '0;
        ReadEnable = '0;
        ReadAddr   = '0;
        rd_ptr_d   = rd_ptr_q;
        last_pos   = -1;
        last_idx   = 0;
        any_rd     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i]   = rreq_i[i] &&
                        !(WriteEnable && (raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == WriteAddr));
            pos[i]    = (i + N_REQ - int'(rd_ptr_q)) % N_REQ;
            rank[i]   = 0;
            port_d[i] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (elig[j] && (pos[j] < pos[i])) begin
                    rank[i] = rank[i] + 1;
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && (rank[i] < N_READ)) begin
                rgnt_o[i] = 1'b1;
                port_d[i] = PW'(rank[i]);
                any_rd    = 1'b1;
                if (pos[i] > last_pos) begin
                    last_pos = pos[i];
                    last_idx = i;
                end
            end
        end
        for (int p = 0; p < N_READ; p++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rgnt_o[i] && (rank[i] == p)) begin
                    ReadEnable[p]                         = 1'b1;
                    ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH]  = raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
        if (any_rd) begin
            rd_ptr_d = RW'(rr_next(last_idx, 1, N_REQ));
        end
    end

    // Read pointer and per-requester return bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            granted_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                port_q[i] <= '0;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            granted_q <= rgnt_o;
            for (int i = 0; i < N_REQ; i++) begin
                port_q[i] <= port_d[i];
            end
        end
    end

    // Route each port's data back to the requester that issued on it.
    always_comb begin
        rvalid_o = granted_q;
        rdata_o  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int p = 0; p < N_READ; p++) begin
                if (granted_q[i] && (port_q[i] == PW'(p))) begin
                    rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = ReadData[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule
